// File: rtl/command_serializer.sv
// command_serializer
// ------------------
// Host-side transmitter for the byte-oriented control command stream. One
// fully-formed command is taken per cmd_valid/cmd_ready handshake. It is then
// sent byte by byte to the pipeline control unit. Each byte is held on
// out_byte/out_ready until the unit returns a one-cycle `next` acknowledge.
//
// Byte order: opcode, [block], [reg], [data MSB..LSB], [instr MSB..LSB].
// The opcode decides which fields are present. Swap commands additionally
// wait for a full high/low cycle of pipelines_swapping before completing.
//
// Opcode map (bit 7 selects the target pipeline; both variants are decoded):
//   0x01/0x81 WRITE_BLOCK_INSTR   0x02/0x82 WRITE_BLOCK_REG
//   0x03/0x83 UPDATE_BLOCK_REG    0x04/0x84 ALLOC_SRAM_DELAY
//   0x05/0x85 SET_INPUT_GAIN      0x06/0x86 SET_OUTPUT_GAIN
//   0x07/0x87 SWAP_PIPELINES      0x08/0x88 RESET_PIPELINE
//
// Optional feature: define COMMAND_SERIALIZER_TIMEOUT_EN to bound every wait
// for `next` or for the swap status to timeout_cycles cycles.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   cmd_valid/cmd_ready  command handshake (ready only while idle)
//   cmd_opcode/_block/_reg/_data/_instr   command fields, latched on accept
//   out_byte/out_ready   byte to the control unit and its valid flag
//   next                 one-cycle byte acknowledge from the control unit
//   pipelines_swapping   swap-in-progress status from the control unit
//   done                 one-cycle pulse when a command completes
//   cmd_unknown          pulse in the accept cycle for unrecognised opcodes
//   timeout              one-cycle pulse on acknowledge timeout (0 if unused)

module command_serializer #(
  parameter int n_blocks             = 32,
  parameter int data_width           = 16,
  parameter int min_gap              = 0,
  parameter int timeout_cycles       = 1024,
  parameter int BLOCK_REG_ADDR_WIDTH = 4,
  parameter int BLOCK_INSTR_WIDTH    = 32,
  localparam int BLOCK_W             = $clog2(n_blocks)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [7:0]                      cmd_opcode,
  input  logic [BLOCK_W-1:0]              cmd_block,
  input  logic [BLOCK_REG_ADDR_WIDTH-1:0] cmd_reg,
  input  logic [data_width-1:0]           cmd_data,
  input  logic [BLOCK_INSTR_WIDTH-1:0]    cmd_instr,
  output logic [7:0]                      out_byte,
  output logic                            out_ready,
  input  logic                            next,
  input  logic                            pipelines_swapping,
  output logic                            done,
  output logic                            cmd_unknown,
  output logic                            timeout
);

  localparam int DATA_BYTES  = data_width / 8;
  localparam int INSTR_BYTES = BLOCK_INSTR_WIDTH / 8;
  localparam int MAX_BYTES   = (DATA_BYTES > INSTR_BYTES) ? DATA_BYTES : INSTR_BYTES;
  localparam int CNT_W       = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int GAP_LOAD    = (min_gap > 0) ? min_gap - 1 : 0;

  localparam logic [7:0] PIPE_SEL              = 8'h80;
  localparam logic [7:0] OP_WRITE_BLOCK_INSTR  = 8'h01;
  localparam logic [7:0] OP_WRITE_BLOCK_REG    = 8'h02;
  localparam logic [7:0] OP_UPDATE_BLOCK_REG   = 8'h03;
  localparam logic [7:0] OP_ALLOC_SRAM_DELAY   = 8'h04;
  localparam logic [7:0] OP_SET_INPUT_GAIN     = 8'h05;
  localparam logic [7:0] OP_SET_OUTPUT_GAIN    = 8'h06;
  localparam logic [7:0] OP_SWAP_PIPELINES     = 8'h07;
  localparam logic [7:0] OP_RESET_PIPELINE     = 8'h08;

  typedef enum logic [3:0] {
    S_IDLE, S_OPCODE, S_BLOCK, S_REG, S_DATA, S_INSTR,
    S_GAP, S_SWAP_WAIT_HI, S_SWAP_WAIT_LO, S_FINISH
  } state_t;

  typedef struct packed {
    logic known;
    logic has_block;
    logic has_reg;
    logic has_data;
    logic has_instr;
    logic is_swap;
  } field_set_t;

  function automatic field_set_t decode_opcode(input logic [7:0] op);
    field_set_t f;
    f = '0;
    case (op)
      OP_WRITE_BLOCK_INSTR, OP_WRITE_BLOCK_INSTR | PIPE_SEL: begin
        f.known = 1'b1; f.has_block = 1'b1; f.has_instr = 1'b1;
      end
      OP_WRITE_BLOCK_REG, OP_WRITE_BLOCK_REG | PIPE_SEL,
      OP_UPDATE_BLOCK_REG, OP_UPDATE_BLOCK_REG | PIPE_SEL: begin
        f.known = 1'b1; f.has_block = 1'b1; f.has_reg = 1'b1; f.has_data = 1'b1;
      end
      OP_ALLOC_SRAM_DELAY, OP_ALLOC_SRAM_DELAY | PIPE_SEL,
      OP_SET_INPUT_GAIN, OP_SET_INPUT_GAIN | PIPE_SEL,
      OP_SET_OUTPUT_GAIN, OP_SET_OUTPUT_GAIN | PIPE_SEL: begin
        f.known = 1'b1; f.has_data = 1'b1;
      end
      OP_SWAP_PIPELINES, OP_SWAP_PIPELINES | PIPE_SEL: begin
        f.known = 1'b1; f.is_swap = 1'b1;
      end
      OP_RESET_PIPELINE, OP_RESET_PIPELINE | PIPE_SEL: begin
        f.known = 1'b1;
      end
      default: f = '0;
    endcase
    return f;
  endfunction

  // Byte presented while sitting in send state s at byte index idx.
  function automatic logic [7:0] byte_of(
    input state_t                            s,
    input logic [CNT_W-1:0]                  idx,
    input logic [BLOCK_W-1:0]                blk,
    input logic [BLOCK_REG_ADDR_WIDTH-1:0]   rg,
    input logic [data_width-1:0]             d,
    input logic [BLOCK_INSTR_WIDTH-1:0]      ins
  );
    logic [7:0] b;
    b = '0;
    case (s)
      S_BLOCK: b = 8'(blk);
      S_REG:   b = 8'(rg);
      S_DATA:  b = d[{idx, 3'b000} +: 8];
      S_INSTR: b = ins[{idx, 3'b000} +: 8];
      default: b = '0;
    endcase
    return b;
  endfunction

  state_t                          state_reg, state_next;
  state_t                          gap_state_reg, gap_state_next;
  logic [7:0]                      opcode_reg, opcode_next;
  logic [BLOCK_W-1:0]              blk_reg, blk_next;
  logic [BLOCK_REG_ADDR_WIDTH-1:0] rix_reg, rix_next;
  logic [data_width-1:0]           data_reg, data_next;
  logic [BLOCK_INSTR_WIDTH-1:0]    instr_reg, instr_next;
  logic [CNT_W-1:0]                byte_cnt_reg, byte_cnt_next;
  logic [CNT_W-1:0]                gap_byte_cnt_reg, gap_byte_cnt_next;
  logic [3:0]                      gap_cnt_reg, gap_cnt_next;
  logic [7:0]                      out_byte_reg, out_byte_next;
  logic                            out_ready_reg, out_ready_next;

  field_set_t                      fs;
  logic                            ack;
  state_t                          follow_state;
  logic [CNT_W-1:0]                follow_cnt;
  logic                            last_byte;

`ifdef COMMAND_SERIALIZER_TIMEOUT_EN
  localparam int TIMER_W = $clog2(timeout_cycles + 1);
  logic [TIMER_W-1:0]              timer_reg, timer_next;
  logic                            timeout_reg, timeout_next;
  logic                            waiting;
`endif

  assign fs  = decode_opcode(opcode_reg);
  // Acknowledges only count while a byte is actually on offer.
  assign ack = next && out_ready_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= S_IDLE;
      gap_state_reg    <= S_IDLE;
      opcode_reg       <= '0;
      blk_reg          <= '0;
      rix_reg          <= '0;
      data_reg         <= '0;
      instr_reg        <= '0;
      byte_cnt_reg     <= '0;
      gap_byte_cnt_reg <= '0;
      gap_cnt_reg      <= '0;
      out_byte_reg     <= '0;
      out_ready_reg    <= 1'b0;
`ifdef COMMAND_SERIALIZER_TIMEOUT_EN
      timer_reg        <= '0;
      timeout_reg      <= 1'b0;
`endif
    end else begin
      state_reg        <= state_next;
      gap_state_reg    <= gap_state_next;
      opcode_reg       <= opcode_next;
      blk_reg          <= blk_next;
      rix_reg          <= rix_next;
      data_reg         <= data_next;
      instr_reg        <= instr_next;
      byte_cnt_reg     <= byte_cnt_next;
      gap_byte_cnt_reg <= gap_byte_cnt_next;
      gap_cnt_reg      <= gap_cnt_next;
      out_byte_reg     <= out_byte_next;
      out_ready_reg    <= out_ready_next;
`ifdef COMMAND_SERIALIZER_TIMEOUT_EN
      timer_reg        <= timer_next;
      timeout_reg      <= timeout_next;
`endif
    end
  end

  always_comb begin
    state_next        = state_reg;
    gap_state_next    = gap_state_reg;
    opcode_next       = opcode_reg;
    blk_next          = blk_reg;
    rix_next          = rix_reg;
    data_next         = data_reg;
    instr_next        = instr_reg;
    byte_cnt_next     = byte_cnt_reg;
    gap_byte_cnt_next = gap_byte_cnt_reg;
    gap_cnt_next      = gap_cnt_reg;
    out_byte_next     = out_byte_reg;
    out_ready_next    = out_ready_reg;
    follow_state      = S_FINISH;
    follow_cnt        = '0;
    last_byte         = 1'b0;

    // Work out which byte follows the current one; absent fields are skipped.
    if ((state_reg == S_DATA || state_reg == S_INSTR) && byte_cnt_reg != '0) begin
      follow_state = state_reg;
      follow_cnt   = byte_cnt_reg - 1'b1;
    end else if (state_reg == S_OPCODE && fs.has_block) begin
      follow_state = S_BLOCK;
    end else if ((state_reg inside {S_OPCODE, S_BLOCK}) && fs.has_reg) begin
      follow_state = S_REG;
    end else if ((state_reg inside {S_OPCODE, S_BLOCK, S_REG}) && fs.has_data) begin
      follow_state = S_DATA;
      follow_cnt   = CNT_W'(DATA_BYTES - 1);
    end else if ((state_reg inside {S_OPCODE, S_BLOCK, S_REG, S_DATA}) && fs.has_instr) begin
      follow_state = S_INSTR;
      follow_cnt   = CNT_W'(INSTR_BYTES - 1);
    end else begin
      last_byte    = 1'b1;
      follow_state = fs.is_swap ? S_SWAP_WAIT_HI : S_FINISH;
    end

    case (state_reg)
      S_IDLE: begin
        if (cmd_valid) begin
          opcode_next    = cmd_opcode;
          blk_next       = cmd_block;
          rix_next       = cmd_reg;
          data_next      = cmd_data;
          instr_next     = cmd_instr;
          byte_cnt_next  = '0;
          out_byte_next  = cmd_opcode;
          out_ready_next = 1'b1;
          state_next     = S_OPCODE;
        end
      end
      S_OPCODE, S_BLOCK, S_REG, S_DATA, S_INSTR: begin
        if (ack) begin
          if (last_byte) begin
            out_ready_next = 1'b0;
            out_byte_next  = '0;
            state_next     = follow_state;
          end else if (min_gap > 0) begin
            out_ready_next    = 1'b0;
            gap_state_next    = follow_state;
            gap_byte_cnt_next = follow_cnt;
            gap_cnt_next      = 4'(GAP_LOAD);
            state_next        = S_GAP;
          end else begin
            // Back-to-back: the next byte replaces the acknowledged one.
            byte_cnt_next  = follow_cnt;
            out_byte_next  = byte_of(follow_state, follow_cnt, blk_reg, rix_reg,
                                     data_reg, instr_reg);
            out_ready_next = 1'b1;
            state_next     = follow_state;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt_reg == '0) begin
          byte_cnt_next  = gap_byte_cnt_reg;
          out_byte_next  = byte_of(gap_state_reg, gap_byte_cnt_reg, blk_reg, rix_reg,
                                   data_reg, instr_reg);
          out_ready_next = 1'b1;
          state_next     = gap_state_reg;
        end else begin
          gap_cnt_next = gap_cnt_reg - 1'b1;
        end
      end
      S_SWAP_WAIT_HI: if (pipelines_swapping) state_next = S_SWAP_WAIT_LO;
      S_SWAP_WAIT_LO: if (!pipelines_swapping) state_next = S_FINISH;
      S_FINISH:       state_next = S_IDLE;
      default:        state_next = S_IDLE;
    endcase

`ifdef COMMAND_SERIALIZER_TIMEOUT_EN
    // Count only cycles spent stalled on the control unit; any progress clears.
    waiting = (out_ready_reg && !next) ||
              (state_reg == S_SWAP_WAIT_HI && !pipelines_swapping) ||
              (state_reg == S_SWAP_WAIT_LO && pipelines_swapping);
    timeout_next = 1'b0;
    timer_next   = '0;
    if (waiting) begin
      if (timer_reg == TIMER_W'(timeout_cycles - 1)) begin
        timeout_next   = 1'b1;
        state_next     = S_IDLE;
        out_ready_next = 1'b0;
        out_byte_next  = '0;
      end else begin
        timer_next = timer_reg + 1'b1;
      end
    end
`endif
  end

  assign cmd_ready   = (state_reg == S_IDLE);
  assign done        = (state_reg == S_FINISH);
  assign cmd_unknown = !reset && cmd_valid && cmd_ready && !decode_opcode(cmd_opcode).known;
  assign out_byte    = out_byte_reg;
  assign out_ready   = out_ready_reg;
`ifdef COMMAND_SERIALIZER_TIMEOUT_EN
  assign timeout     = timeout_reg;
`else
  assign timeout     = 1'b0;
`endif

endmodule

// File: tb/tb_command_serializer.sv
// Testbench for command_serializer. Two instances share the clock: g_dut[0]
// without inter-byte gap and g_dut[1] with min_gap=2. Expected bytes are
// queued when a command is issued and popped by a per-instance responder that
// acknowledges each byte two cycles after it appears.

module tb_command_serializer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset              [2];
  logic        cmd_valid          [2];
  logic        cmd_ready          [2];
  logic [7:0]  cmd_opcode         [2];
  logic [4:0]  cmd_block          [2];
  logic [3:0]  cmd_reg            [2];
  logic [15:0] cmd_data           [2];
  logic [31:0] cmd_instr          [2];
  logic [7:0]  out_byte           [2];
  logic        out_ready          [2];
  logic        next               [2];
  logic        pipelines_swapping [2];
  logic        done               [2];
  logic        cmd_unknown        [2];
  logic        timeout            [2];

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [7:0]  exp_q [$];

  bit          resp_en  [2];
  int          ack_cnt  [2] = '{0, 0};
  int          done_cnt [2] = '{0, 0};
  int          done_cyc [2] = '{0, 0};
  int          to_cnt   [2] = '{0, 0};
  int          to_cyc   [2] = '{0, 0};
  int          exp_gap  [2] = '{0, 2};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    command_serializer #(
      .n_blocks(32), .data_width(16), .min_gap(2 * gi), .timeout_cycles(16),
      .BLOCK_REG_ADDR_WIDTH(4), .BLOCK_INSTR_WIDTH(32)
    ) u_dut (
      .clk(clk), .reset(reset[gi]),
      .cmd_valid(cmd_valid[gi]), .cmd_ready(cmd_ready[gi]),
      .cmd_opcode(cmd_opcode[gi]), .cmd_block(cmd_block[gi]), .cmd_reg(cmd_reg[gi]),
      .cmd_data(cmd_data[gi]), .cmd_instr(cmd_instr[gi]),
      .out_byte(out_byte[gi]), .out_ready(out_ready[gi]), .next(next[gi]),
      .pipelines_swapping(pipelines_swapping[gi]),
      .done(done[gi]), .cmd_unknown(cmd_unknown[gi]), .timeout(timeout[gi])
    );

    // Responder/monitor: acks each byte 2 cycles after it appears, checks it
    // against the queue, checks it was held, and checks the inter-byte gap.
    // Instance 1 also pulses next while out_ready is low; that must be ignored.
    initial begin
      int         wc = 0;
      int         ack_at = 0;
      bit         mid = 0;
      logic [7:0] seen = '0;
      forever begin
        @(negedge clk);
        next[gi] = 1'b0;
        if (reset[gi]) mid = 0;
        if (done[gi]) begin
          done_cnt[gi]++;
          done_cyc[gi] = cyc;
          mid = 0;
        end
        if (timeout[gi]) begin
          to_cnt[gi]++;
          to_cyc[gi] = cyc;
          mid = 0;
        end
        if (out_ready[gi] && resp_en[gi]) begin
          if (wc == 0) begin
            seen = out_byte[gi];
            if (mid) check($sformatf("gap%0d", gi), cyc - ack_at - 1, exp_gap[gi]);
          end
          if (wc == 2) begin
            check($sformatf("hold%0d", gi), out_byte[gi], seen);
            check($sformatf("queue_nonempty%0d", gi), exp_q.size() != 0, 1);
            if (exp_q.size() != 0)
              check($sformatf("byte%0d", gi), out_byte[gi], exp_q.pop_front());
            next[gi] = 1'b1;
            ack_cnt[gi]++;
            ack_at = cyc;
            mid = 1;
            wc = 0;
          end else begin
            wc++;
          end
        end else begin
          wc = 0;
          if (gi == 1 && !out_ready[gi]) next[gi] = 1'b1;
        end
      end
    end
  end

  task automatic send(input int s, input logic [7:0] op, input logic [4:0] blk,
                      input logic [3:0] rg, input logic [15:0] dat,
                      input logic [31:0] ins, input logic exp_unk);
    int n;
    @(negedge clk);
    cmd_opcode[s] = op;
    cmd_block[s]  = blk;
    cmd_reg[s]    = rg;
    cmd_data[s]   = dat;
    cmd_instr[s]  = ins;
    cmd_valid[s]  = 1'b1;
    #1;
    n = 0;
    while (!cmd_ready[s] && n < 300) begin
      @(negedge clk); #1; n++;
    end
    check("accept", n < 300, 1);
    check("cmd_unknown", cmd_unknown[s], exp_unk);
    @(negedge clk);
    // Scramble the inputs: the DUT must use the latched copy.
    cmd_valid[s]  = 1'b0;
    cmd_opcode[s] = 8'h5A;
    cmd_block[s]  = ~blk;
    cmd_reg[s]    = ~rg;
    cmd_data[s]   = ~dat;
    cmd_instr[s]  = ~ins;
    #1;
    check("first_ready", out_ready[s], 1);
    check("first_byte", out_byte[s], op);
  endtask

  task automatic wait_done(input int s, input string tag);
    int d0, n;
    d0 = done_cnt[s];
    n = 0;
    while (done_cnt[s] == d0 && n < 300) begin
      @(negedge clk); #1; n++;
    end
    check({tag, "_done"}, n < 300, 1);
    repeat (3) @(negedge clk);
    #1;
    check({tag, "_single_done"}, done_cnt[s] - d0, 1);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_idle"}, cmd_ready[s], 1);
    $display("cmd %s on dut%0d complete at cycle %0d", tag, s, done_cyc[s]);
  endtask

  initial begin
    int a0, d0, n, early, fall;
    for (int s = 0; s < 2; s++) begin
      reset[s] = 1'b1; cmd_valid[s] = 1'b0; pipelines_swapping[s] = 1'b0;
      cmd_opcode[s] = '0; cmd_block[s] = '0; cmd_reg[s] = '0;
      cmd_data[s] = '0; cmd_instr[s] = '0; resp_en[s] = 1'b1;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check("rst_cmd_ready", cmd_ready[s], 1);
      check("rst_out_ready", out_ready[s], 0);
      check("rst_out_byte", out_byte[s], 0);
      check("rst_done", done[s], 0);
      check("rst_unknown", cmd_unknown[s], 0);
      check("rst_timeout", timeout[s], 0);
    end
    reset[0] = 1'b0; reset[1] = 1'b0;

    // WRITE_BLOCK_REG block 5 reg 3 data 0xABCD
    exp_q = '{8'h02, 8'h05, 8'h03, 8'hAB, 8'hCD};
    send(0, 8'h02, 5'd5, 4'd3, 16'hABCD, 32'h0, 1'b0);
    wait_done(0, "write_block_reg");

    // WRITE_BLOCK_INSTR (pipeline-select variant) block 31 instr 0x12345678
    exp_q = '{8'h81, 8'h1F, 8'h12, 8'h34, 8'h56, 8'h78};
    send(0, 8'h81, 5'd31, 4'd7, 16'hFFFF, 32'h12345678, 1'b0);
    wait_done(0, "write_block_instr");

    // Gap instance: SET_INPUT_GAIN 0x0100, then UPDATE_BLOCK_REG variant
    exp_q = '{8'h05, 8'h01, 8'h00};
    send(1, 8'h05, 5'd9, 4'd2, 16'h0100, 32'hDEADBEEF, 1'b0);
    wait_done(1, "gap_input_gain");
    exp_q = '{8'h83, 8'h02, 8'h09, 8'h12, 8'h34};
    send(1, 8'h83, 5'd2, 4'd9, 16'h1234, 32'h0, 1'b0);
    wait_done(1, "gap_update_reg");

    // Unknown opcodes: single byte, cmd_unknown pulse, done
    exp_q = '{8'hEE};
    send(0, 8'hEE, 5'd1, 4'd1, 16'h1111, 32'h1, 1'b1);
    wait_done(0, "unknown_ee");
    exp_q = '{8'h41};
    send(1, 8'h41, 5'd1, 4'd1, 16'h1111, 32'h1, 1'b1);
    wait_done(1, "unknown_41");

    // SWAP_PIPELINES with a second command held on cmd_valid throughout
    a0 = ack_cnt[0];
    d0 = done_cnt[0];
    exp_q = '{8'h07};
    send(0, 8'h07, 5'd0, 4'd0, 16'h0, 32'h0, 1'b0);
    n = 0;
    while (ack_cnt[0] == a0 && n < 50) begin
      @(negedge clk); #1; n++;
    end
    check("swap_ack", n < 50, 1);
    exp_q.push_back(8'h08);
    cmd_opcode[0] = 8'h08;
    cmd_valid[0]  = 1'b1;
    early = 0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i == 3) pipelines_swapping[0] = 1'b1;
      #1;
      early += int'(cmd_ready[0]);
    end
    @(negedge clk);
    pipelines_swapping[0] = 1'b0;
    fall = cyc;
    #1;
    early += int'(cmd_ready[0]);
    check("swap_hold_off", early, 0);
    check("swap_no_early_done", done_cnt[0], d0);
    n = 0;
    while (done_cnt[0] == d0 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check("swap_done_seen", n < 20, 1);
    check("swap_done_latency", done_cyc[0] - fall, 1);
    $display("cmd swap on dut0 complete at cycle %0d", done_cyc[0]);
    @(negedge clk); #1;
    check("swap_ready_after", cmd_ready[0], 1);
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    wait_done(0, "held_reset_pipeline");

    // Reset after the 2nd byte of WRITE_BLOCK_REG
    a0 = ack_cnt[0];
    exp_q = '{8'h02, 8'h05, 8'h03, 8'hAB, 8'hCD};
    send(0, 8'h02, 5'd5, 4'd3, 16'hABCD, 32'h0, 1'b0);
    n = 0;
    while (ack_cnt[0] < a0 + 2 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("midrst_two_acks", n < 100, 1);
    @(negedge clk);
    reset[0] = 1'b1;
    exp_q.delete();
    d0 = done_cnt[0];
    @(negedge clk); #1;
    check("midrst_out_ready", out_ready[0], 0);
    check("midrst_idle", cmd_ready[0], 1);
    reset[0] = 1'b0;
    repeat (6) @(negedge clk);
    #1;
    check("midrst_no_done", done_cnt[0], d0);
    $display("cmd reset-abort on dut0 at cycle %0d", cyc);
    exp_q = '{8'h88};
    send(0, 8'h88, 5'd0, 4'd0, 16'h0, 32'h0, 1'b0);
    wait_done(0, "after_reset");

`ifdef COMMAND_SERIALIZER_TIMEOUT_EN
    begin
      int t0, r;
      resp_en[0] = 1'b0;
      d0 = done_cnt[0];
      t0 = to_cnt[0];
      send(0, 8'h02, 5'd1, 4'd1, 16'h0, 32'h0, 1'b0);
      r = cyc;
      n = 0;
      while (to_cnt[0] == t0 && n < 100) begin
        @(negedge clk); #1; n++;
      end
      check("to_seen", n < 100, 1);
      check("to_latency", to_cyc[0] - r, 16);
      check("to_out_ready", out_ready[0], 0);
      check("to_idle", cmd_ready[0], 1);
      check("to_no_done", done_cnt[0], d0);
      $display("cmd timeout on dut0 at cycle %0d", to_cyc[0]);
      resp_en[0] = 1'b1;
    end
`else
    check("no_timeout", to_cnt[0] + to_cnt[1], 0);
`endif

    check("final_queue", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
